vel_sweep_sched: RTL and testbench

Sequencer for one velocity-solve pass over the fluid field. It walks every cell in red-black (checkerboard) order. For each cell it drives `field_x`/`field_y` to the per-cell solver and then to the velocity write-back unit, handshaking with each via start/done pulses. It repeats the full red+black sweep a programmable number of iterations and sits between the top-level frame controller and the solve/write datapath.

---
 rtl/vel_sweep_sched_if.sv | 30 +++
 rtl/vel_sweep_sched.sv | 158 +++++++++++++++
 tb/tb_vel_sweep_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vel_sweep_sched_if.sv
// Handshake bundle between the frame controller, the sweep sequencer and the
// per-cell solve/write datapath. The sequencer takes the slave side.
interface vel_sweep_sched_if #(
    parameter int ITER_W = 8
);
    logic              start;
    logic [ITER_W-1:0] iters;
    logic              busy;
    logic              done;
    logic [31:0]       field_x;
    logic [31:0]       field_y;
    logic              color;
    logic [ITER_W-1:0] iter_idx;
    logic              solve_start;
    logic              solve_done;
    logic              write_start;
    logic              write_done;

    modport slave (
        input  start, iters, solve_done, write_done,
        output busy, done, field_x, field_y, color, iter_idx,
               solve_start, write_start
    );

    modport master (
        output start, iters, solve_done, write_done,
        input  busy, done, field_x, field_y, color, iter_idx,
               solve_start, write_start
    );
endinterface

// File: rtl/vel_sweep_sched.sv
// Red-black velocity sweep sequencer: walks every cell in checkerboard order,
// handshakes each cell with the solver then the writer, and repeats for iters passes.
module vel_sweep_sched #(
    parameter int FIELD_WIDTH  = 8,
    parameter int FIELD_HEIGHT = 6,
    parameter int ITER_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    vel_sweep_sched_if.slave sif
);
    localparam int XW = $clog2(FIELD_WIDTH + 1);
    localparam int YW = $clog2(FIELD_HEIGHT + 1);

    generate
        if (FIELD_WIDTH < 2) begin : g_bad_width
            $error("FIELD_WIDTH must be at least 2");
        end
        if (FIELD_HEIGHT < 1) begin : g_bad_height
            $error("FIELD_HEIGHT must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOLVE_REQ,
        S_SOLVE_WAIT,
        S_WRITE_REQ,
        S_WRITE_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_color;
    logic [ITER_W-1:0] r_iter;
    logic [ITER_W-1:0] r_iters;
    logic              r_busy;
    logic              r_done;
    logic              r_solve_start;
    logic              r_write_start;

    logic [XW:0]       w_x_step;
    logic [YW:0]       w_y_step;
    logic              w_row_wrap;
    logic              w_col_wrap;
    logic [ITER_W-1:0] w_iter_inc;
    logic              w_pass_end;
    logic [XW-1:0]     w_x_next;
    logic [YW-1:0]     w_y_next;

    // Next-cell walk: step by two along a row; a new row restarts on the
    // first column of the current parity; the last row flips colour.
    assign w_x_step   = {1'b0, r_x} + (XW+1)'(2);
    assign w_row_wrap = (w_x_step >= (XW+1)'(FIELD_WIDTH));
    assign w_y_step   = {1'b0, r_y} + (YW+1)'(1);
    assign w_col_wrap = w_row_wrap && (w_y_step == (YW+1)'(FIELD_HEIGHT));
    assign w_iter_inc = r_iter + ITER_W'(1);
    assign w_pass_end = w_col_wrap && r_color && (w_iter_inc == r_iters);

    assign w_x_next = !w_row_wrap ? w_x_step[XW-1:0] :
                      !w_col_wrap ? XW'(w_y_step[0] ^ r_color) :
                                    XW'(!r_color);
    assign w_y_next = !w_row_wrap ? r_y :
                      !w_col_wrap ? w_y_step[YW-1:0] :
                                    '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_color       <= 1'b0;
            r_iter        <= '0;
            r_iters       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_solve_start <= 1'b0;
            r_write_start <= 1'b0;
        end else begin
            r_solve_start <= 1'b0;
            r_write_start <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sif.start) begin
                        r_iters <= sif.iters;
                        r_iter  <= '0;
                        r_color <= 1'b0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_busy  <= 1'b1;
                        if (sif.iters == '0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= S_SOLVE_REQ;
                            r_solve_start <= 1'b1;
                        end
                    end
                end
                S_SOLVE_REQ: begin
                    r_state <= S_SOLVE_WAIT;
                end
                S_SOLVE_WAIT: begin
                    if (sif.solve_done) begin
                        r_state       <= S_WRITE_REQ;
                        r_write_start <= 1'b1;
                    end
                end
                S_WRITE_REQ: begin
                    r_state <= S_WRITE_WAIT;
                end
                S_WRITE_WAIT: begin
                    if (sif.write_done) begin
                        r_state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    r_x <= w_x_next;
                    r_y <= w_y_next;
                    if (w_col_wrap) begin
                        r_color <= !r_color;
                        if (r_color) begin
                            r_iter <= w_iter_inc;
                        end
                    end
                    if (w_pass_end) begin
                        r_state <= S_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_state       <= S_SOLVE_REQ;
                        r_solve_start <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sif.busy        = r_busy;
    assign sif.done        = r_done;
    assign sif.solve_start = r_solve_start;
    assign sif.write_start = r_write_start;
    assign sif.field_x     = 32'(r_x);
    assign sif.field_y     = 32'(r_y);
    assign sif.color       = r_color;
    assign sif.iter_idx    = r_iter;
endmodule

// File: tb/tb_vel_sweep_sched.sv
// Directed bench for vel_sweep_sched on the default 8x6 field with a
// solver/writer responder model and a visit monitor.
module tb_vel_sweep_sched;
    localparam int ITER_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vel_sweep_sched_if #(.ITER_W(ITER_W)) sif ();

    vel_sweep_sched #(
        .FIELD_WIDTH (8),
        .FIELD_HEIGHT(6),
        .ITER_W      (ITER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sif(sif)
    );

    int tests = 0;
    int fails = 0;

    int   s_delay = 1, w_delay = 3, stall_len = 0;
    int   stall_x = -1, stall_y = -1;
    int   s_cnt = 0, w_cnt = 0;
    logic sd_r = 1'b0, wd_r = 1'b0, spur_wd = 1'b0;

    assign sif.solve_done = sd_r;
    assign sif.write_done = wd_r | spur_wd;

    int   q_x[$], q_y[$], q_c[$], q_i[$];
    int   n_solve = 0, n_write = 0, hold_err = 0, toggles = 0;
    int   cur_x = 0, cur_y = 0;
    logic prev_c = 1'b0;

    // Responder and monitor: reacts one time unit after each rising edge.
    initial begin : responder
        forever begin
            @(posedge clk); #1;
            sd_r = 1'b0;
            wd_r = 1'b0;
            if (s_cnt > 0) begin s_cnt--; if (s_cnt == 0) sd_r = 1'b1; end
            if (w_cnt > 0) begin w_cnt--; if (w_cnt == 0) wd_r = 1'b1; end
            if (sif.solve_start === 1'b1) begin
                cur_x = int'(sif.field_x);
                cur_y = int'(sif.field_y);
                s_cnt = (cur_x == stall_x && cur_y == stall_y) ? stall_len : s_delay;
                q_x.push_back(cur_x);
                q_y.push_back(cur_y);
                q_c.push_back(int'(sif.color));
                q_i.push_back(int'(sif.iter_idx));
                n_solve++;
            end
            if (sif.write_start === 1'b1) begin
                w_cnt = w_delay;
                n_write++;
                if (int'(sif.field_x) != cur_x || int'(sif.field_y) != cur_y) hold_err++;
            end
            if (sif.color !== prev_c) toggles++;
            prev_c = sif.color;
        end
    end

    task automatic clear_mon();
        q_x.delete(); q_y.delete(); q_c.delete(); q_i.delete();
        n_solve = 0; n_write = 0; hold_err = 0; toggles = 0;
        prev_c = sif.color;
    endtask

    task automatic run_pass(input logic [ITER_W-1:0] it, input int bound, input int poke_at,
                            input logic [ITER_W-1:0] poke_it, output int dc);
        int n;
        @(posedge clk); #2;
        sif.start = 1'b1;
        sif.iters = it;
        n  = 0;
        dc = -1;
        while (n < bound && dc < 0) begin
            @(posedge clk); #2;
            n++;
            if (n == poke_at) begin
                sif.start = 1'b1;
                sif.iters = poke_it;
            end else begin
                sif.start = 1'b0;
            end
            if (sif.done === 1'b1) dc = n;
        end
        sif.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sif.start = 1'b0;
        sif.iters = '0;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if ({sif.busy, sif.done, sif.solve_start, sif.write_start, sif.color} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {sif.busy, sif.done, sif.solve_start, sif.write_start, sif.color});
        end
        tests++;
        if (sif.field_x !== 32'd0 || sif.field_y !== 32'd0) begin
            fails++;
            $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", sif.field_x, sif.field_y);
        end
        tests++;
        if (sif.iter_idx !== '0) begin
            fails++;
            $display("FAIL reset_iter: got %0d expected 0", sif.iter_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_pass();
        int   dc, errs;
        bit   [95:0] seen;
        int   ex[5] = '{0, 2, 4, 6, 1};
        int   ey[5] = '{0, 0, 0, 0, 1};
        clear_mon();
        run_pass(8'd1, 2000, -1, 8'd0, dc);
        tests++;
        if (dc !== 337) begin
            fails++;
            $display("FAIL single_done_cycle: got %0d expected 337", dc);
        end
        tests++;
        if (n_solve != 48 || n_write != 48) begin
            fails++;
            $display("FAIL single_req_count: got solve=%0d write=%0d expected 48/48", n_solve, n_write);
        end
        tests++;
        if (hold_err != 0) begin
            fails++;
            $display("FAIL single_hold: got %0d cells moved expected 0", hold_err);
        end
        errs = 0;
        if (q_x.size() < 48) errs = 100;
        else begin
            for (int i = 0; i < 5; i++) if (q_x[i] != ex[i] || q_y[i] != ey[i]) errs++;
            if (q_x[24] != 1 || q_y[24] != 0 || q_c[24] != 1) errs++;
            if (q_x[47] != 6 || q_y[47] != 5) errs++;
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL visit_order: got %0d errors expected 0", errs);
        end
        errs = 0;
        seen = '0;
        for (int i = 0; i < q_x.size(); i++) begin
            if (q_x[i] < 0 || q_x[i] > 7 || q_y[i] < 0 || q_y[i] > 5) errs++;
            else begin
                if (seen[q_y[i]*8 + q_x[i]]) errs++;
                seen[q_y[i]*8 + q_x[i]] = 1'b1;
                if (q_c[i] != ((q_x[i] + q_y[i]) & 1)) errs++;
            end
        end
        tests++;
        if (errs != 0 || seen !== {48'd0, {48{1'b1}}}) begin
            fails++;
            $display("FAIL visit_unique: got %0d errors expected 0 and all 48 cells", errs);
        end
        @(posedge clk); #2;
        tests++;
        if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
            fails++;
            $display("FAIL post_done_idle: got busy=%b done=%b expected 0/0", sif.busy, sif.done);
        end
    endtask

    task automatic test_zero_iters();
        int dc;
        clear_mon();
        run_pass(8'd0, 20, -1, 8'd0, dc);
        tests++;
        if (dc !== 1) begin
            fails++;
            $display("FAIL zero_done_cycle: got %0d expected 1", dc);
        end
        @(posedge clk); #2;
        tests++;
        if (n_solve != 0 || n_write != 0) begin
            fails++;
            $display("FAIL zero_no_req: got solve=%0d write=%0d expected 0/0", n_solve, n_write);
        end
    endtask

    task automatic test_multi_iter();
        int dc;
        clear_mon();
        run_pass(8'd3, 4000, -1, 8'd0, dc);
        tests++;
        if (dc !== 1009) begin
            fails++;
            $display("FAIL multi_done_cycle: got %0d expected 1009", dc);
        end
        @(posedge clk); #2;
        tests++;
        if (q_i.size() != 144) begin
            fails++;
            $display("FAIL multi_cells: got %0d expected 144", q_i.size());
        end else begin
            tests++;
            if (q_i[0] != 0 || q_i[47] != 0 || q_i[48] != 1 || q_i[96] != 2 || q_i[143] != 2) begin
                fails++;
                $display("FAIL multi_iter_idx: got %0d,%0d,%0d,%0d,%0d expected 0,0,1,2,2",
                         q_i[0], q_i[47], q_i[48], q_i[96], q_i[143]);
            end
        end
        tests++;
        if (toggles != 6) begin
            fails++;
            $display("FAIL multi_color_toggles: got %0d expected 6", toggles);
        end
    endtask

    task automatic test_stall();
        int n, bad_xy, early_wr;
        clear_mon();
        stall_x = 2; stall_y = 0; stall_len = 50;
        @(posedge clk); #2;
        sif.start = 1'b1;
        sif.iters = 8'd1;
        n = 0;
        while (n < 100 && !(sif.solve_start === 1'b1 && sif.field_x == 32'd2 && sif.field_y == 32'd0)) begin
            @(posedge clk); #2;
            sif.start = 1'b0;
            n++;
        end
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL stall_req_cycle: got %0d expected 8", n);
        end
        bad_xy = 0; early_wr = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #2;
            n++;
            spur_wd = (i == 10);
            if (sif.field_x !== 32'd2 || sif.field_y !== 32'd0) bad_xy++;
            if (sif.write_start !== 1'b0) early_wr++;
        end
        spur_wd = 1'b0;
        tests++;
        if (bad_xy != 0) begin
            fails++;
            $display("FAIL stall_hold_xy: got %0d moved cycles expected 0", bad_xy);
        end
        tests++;
        if (early_wr != 0) begin
            fails++;
            $display("FAIL stall_early_write: got %0d write_start cycles expected 0", early_wr);
        end
        @(posedge clk); #2;
        n++;
        tests++;
        if (sif.write_start !== 1'b1) begin
            fails++;
            $display("FAIL stall_write_after: got %b expected 1", sif.write_start);
        end
        while (n < 1000 && sif.done !== 1'b1) begin
            @(posedge clk); #2;
            n++;
        end
        tests++;
        if (n != 386 || n_solve != 48) begin
            fails++;
            $display("FAIL stall_done_cycle: got %0d (cells %0d) expected 386 (48)", n, n_solve);
        end
        stall_x = -1; stall_y = -1; stall_len = 0;
    endtask

    task automatic test_start_busy();
        int dc;
        clear_mon();
        run_pass(8'd2, 3000, 100, 8'd5, dc);
        tests++;
        if (dc !== 673 || n_solve != 96) begin
            fails++;
            $display("FAIL start_busy: got done=%0d cells=%0d expected 673/96", dc, n_solve);
        end
    endtask

    task automatic test_back_to_back();
        int dc1, dc2;
        clear_mon();
        run_pass(8'd1, 2000, -1, 8'd0, dc1);
        run_pass(8'd1, 2000, -1, 8'd0, dc2);
        tests++;
        if (dc1 !== 337 || dc2 !== 337 || n_solve != 96) begin
            fails++;
            $display("FAIL back_to_back: got %0d,%0d cells=%0d expected 337,337 cells=96", dc1, dc2, n_solve);
        end
    endtask

    task automatic test_reset_mid();
        int n, dc;
        clear_mon();
        @(posedge clk); #2;
        sif.start = 1'b1;
        sif.iters = 8'd2;
        n = 0;
        while (n < 200 && !(sif.write_start === 1'b1 && sif.field_x == 32'd3 && sif.field_y == 32'd1)) begin
            @(posedge clk); #2;
            sif.start = 1'b0;
            n++;
        end
        tests++;
        if (n != 38) begin
            fails++;
            $display("FAIL rstmid_write_cycle: got %0d expected 38", n);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        tests++;
        if ({sif.busy, sif.done, sif.solve_start, sif.write_start, sif.color} !== 5'b0 ||
            sif.field_x !== 32'd0 || sif.field_y !== 32'd0 || sif.iter_idx !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got ctrl=%b x=%0d y=%0d it=%0d expected all 0",
                     {sif.busy, sif.done, sif.solve_start, sif.write_start, sif.color},
                     sif.field_x, sif.field_y, sif.iter_idx);
        end
        repeat (5) @(posedge clk);
        #2;
        tests++;
        if (sif.busy !== 1'b0 || sif.write_start !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_stays_idle: got busy=%b write_start=%b expected 0/0", sif.busy, sif.write_start);
        end
        clear_mon();
        run_pass(8'd1, 2000, -1, 8'd0, dc);
        tests++;
        if (dc !== 337 || q_x.size() == 0 || q_x[0] != 0 || q_y[0] != 0 || q_c[0] != 0) begin
            fails++;
            $display("FAIL rstmid_restart: got done=%0d first=(%0d,%0d,c%0d) expected 337 (0,0,c0)",
                     dc, (q_x.size() > 0) ? q_x[0] : -1, (q_y.size() > 0) ? q_y[0] : -1,
                     (q_c.size() > 0) ? q_c[0] : -1);
        end
    endtask

    initial begin
        sif.start = 1'b0;
        sif.iters = '0;
        test_reset();
        test_single_pass();
        test_zero_iters();
        test_multi_iter();
        test_stall();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
